axi_mem_slave: RTL and testbench

- Synthesizable AXI responder: a word-addressed memory that sits at the slave end of the AXI bus.
- The bench master drives it through the AXI slave interface; the slave monitor observes the same pins.
- Independent write path (AW/W/B) and read path (AR/R); one outstanding transaction per path.
- Burst types FIXED, INCR and WRAP; OKAY/SLVERR/DECERR responses.

---
 rtl/axi_slv_pkg.sv | 49 ++++
 rtl/axi_burst_addr_gen.sv | 44 ++++
 rtl/axi_mem_slave.sv | 257 +++++++++++++++++++++++++
 tb/tb_axi_mem_slave.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_slv_pkg.sv
// Shared types and helpers for the AXI memory responder: burst/response
// encodings, per-path FSM states, and response-merging/wrap helpers.
package axi_slv_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10,
    RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  // Burst-level response: DECERR dominates SLVERR, which dominates OKAY.
  function automatic resp_e worst_resp(input resp_e a, input resp_e b);
    if (a == DECERR || b == DECERR) return DECERR;
    if (a == SLVERR || b == SLVERR) return SLVERR;
    if (a == EXOKAY || b == EXOKAY) return EXOKAY;
    return OKAY;
  endfunction

  // log2(len+1) for the legal WRAP lengths; 0 marks an illegal WRAP length.
  function automatic logic [2:0] wrap_shift(input logic [7:0] len);
    case (len)
      8'd1:    return 3'd1;
      8'd3:    return 3'd2;
      8'd7:    return 3'd3;
      8'd15:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts, plus the
// burst-shape error (oversize beat, bad WRAP length/alignment, reserved type).
module axi_burst_addr_gen
  import axi_slv_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [7:0]        len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr,
  output logic              err
);

  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W / 8));

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] incr;
  logic [ADDR_W-1:0] mask;
  logic [2:0]        shift;

  always_comb begin
    step      = {{(ADDR_W-1){1'b0}}, 1'b1} << size;
    incr      = addr + step;
    shift     = wrap_shift(len);
    mask      = (step << shift) - {{(ADDR_W-1){1'b0}}, 1'b1};
    next_addr = incr;
    err       = (size > MAX_SIZE);
    case (burst_e'(burst))
      FIXED: next_addr = addr;
      INCR:  next_addr = incr;
      WRAP: begin
        // Illegal WRAP lengths fall back to incrementing; the burst is flagged anyway.
        if (shift != 3'd0) next_addr = (addr & ~mask) | (incr & mask);
        if (shift == 3'd0 || (addr & (step - {{(ADDR_W-1){1'b0}}, 1'b1})) != '0) err = 1'b1;
      end
      RSVD: err = 1'b1;
      default: next_addr = incr;
    endcase
  end

endmodule

// File: rtl/axi_mem_slave.sv
// Word-addressed AXI memory responder with independent write (AW/W/B) and
// read (AR/R) paths, one outstanding burst per path.
module axi_mem_slave
  import axi_slv_pkg::*;
#(
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 1024
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ID_W-1:0]     wid,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int WB     = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_DEPTH);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
    return (a >> WB) >= ADDR_W'(MEM_DEPTH);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'(a >> WB);
  endfunction

  // Held low through reset so every output is 0 until the first edge after release.
  logic live;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) live <= 1'b0;
    else          live <= 1'b1;
  end

  // Valid/ready: a beat moves on a rising edge with valid && ready high; every
  // output is a register (or a decode of one) and holds while valid && !ready.

  // ---------------- write path ----------------
  wr_state_e         w_state, w_state_nxt;
  logic [ID_W-1:0]   w_id;
  logic [ADDR_W-1:0] w_addr, w_next_addr;
  logic [7:0]        w_len, w_beat;
  logic [2:0]        w_size;
  logic [1:0]        w_burst;
  logic              w_gen_err, aw_fire, w_fire, w_last_beat;
  resp_e             w_acc, w_beat_resp;
  logic [ID_W-1:0]   bid_q;
  resp_e             bresp_q;

  axi_burst_addr_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr_gen (
    .addr      (w_addr),
    .size      (w_size),
    .len       (w_len),
    .burst     (w_burst),
    .next_addr (w_next_addr),
    .err       (w_gen_err)
  );

  assign aw_fire     = awvalid && awready;
  assign w_fire      = wvalid && wready;
  assign w_last_beat = (w_beat == w_len);

  always_comb begin
    if (out_of_range(w_addr))                                  w_beat_resp = DECERR;
    else if (w_gen_err || wid != w_id || wlast != w_last_beat) w_beat_resp = SLVERR;
    else                                                       w_beat_resp = OKAY;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) w_state <= W_IDLE;
    else          w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (aw_fire) w_state_nxt = W_DATA;
      W_DATA:  if (w_fire && w_last_beat) w_state_nxt = W_RESP;
      W_RESP:  if (bready) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    awready = live && (w_state == W_IDLE);
    wready  = (w_state == W_DATA);
    bvalid  = (w_state == W_RESP);
    bid     = bid_q;
    bresp   = bresp_q;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_beat  <= '0;
      w_acc   <= OKAY;
      bid_q   <= '0;
      bresp_q <= OKAY;
    end else if (aw_fire) begin
      w_id    <= awid;
      w_addr  <= awaddr;
      w_len   <= awlen;
      w_size  <= awsize;
      w_burst <= awburst;
      w_beat  <= '0;
      w_acc   <= OKAY;
    end else if (w_fire) begin
      w_addr <= w_next_addr;
      w_beat <= w_beat + 8'd1;
      w_acc  <= worst_resp(w_acc, w_beat_resp);
      if (w_last_beat) begin
        bid_q   <= w_id;
        bresp_q <= worst_resp(w_acc, w_beat_resp);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (w_fire && !out_of_range(w_addr)) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) mem[word_idx(w_addr)][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  rd_state_e         r_state, r_state_nxt;
  logic [ADDR_W-1:0] r_addr, r_next_addr, rg_addr, r_src_addr;
  logic [7:0]        r_len, r_beat, rg_len;
  logic [2:0]        r_size, rg_size;
  logic [1:0]        r_burst, rg_burst;
  logic              r_err, r_gen_err, ar_fire, r_fire;
  logic [DATA_W-1:0] r_src_data;
  logic [ID_W-1:0]   rid_q;
  logic [DATA_W-1:0] rdata_q;
  resp_e             rresp_q;
  logic              rlast_q;

  // While idle the generator looks at the AR channel so the first beat's error is known at capture.
  always_comb begin
    rg_addr  = r_addr;
    rg_size  = r_size;
    rg_len   = r_len;
    rg_burst = r_burst;
    if (r_state == R_IDLE) begin
      rg_addr  = araddr;
      rg_size  = arsize;
      rg_len   = arlen;
      rg_burst = arburst;
    end
  end

  axi_burst_addr_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rd_gen (
    .addr      (rg_addr),
    .size      (rg_size),
    .len       (rg_len),
    .burst     (rg_burst),
    .next_addr (r_next_addr),
    .err       (r_gen_err)
  );

  assign ar_fire    = arvalid && arready;
  assign r_fire     = rvalid && rready;
  assign r_src_addr = (r_state == R_IDLE) ? araddr : r_next_addr;
  assign r_src_data = out_of_range(r_src_addr) ? '0 : mem[word_idx(r_src_addr)];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= R_IDLE;
    else          r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_fire) r_state_nxt = R_DATA;
      R_DATA:  if (r_fire && rlast_q) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    arready = live && (r_state == R_IDLE);
    rvalid  = (r_state == R_DATA);
    rid     = rid_q;
    rdata   = rdata_q;
    rresp   = rresp_q;
    rlast   = rlast_q;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_beat  <= '0;
      r_err   <= 1'b0;
      rid_q   <= '0;
      rdata_q <= '0;
      rresp_q <= OKAY;
      rlast_q <= 1'b0;
    end else if (ar_fire) begin
      r_addr  <= araddr;
      r_len   <= arlen;
      r_size  <= arsize;
      r_burst <= arburst;
      r_beat  <= '0;
      r_err   <= r_gen_err;
      rid_q   <= arid;
      rlast_q <= (arlen == 8'd0);
      rdata_q <= r_src_data;
      rresp_q <= out_of_range(araddr) ? DECERR : (r_gen_err ? SLVERR : OKAY);
    end else if (r_fire && !rlast_q) begin
      r_addr  <= r_next_addr;
      r_beat  <= r_beat + 8'd1;
      rlast_q <= ((r_beat + 8'd1) == r_len);
      rdata_q <= r_src_data;
      rresp_q <= out_of_range(r_next_addr) ? DECERR : (r_err ? SLVERR : OKAY);
    end
  end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave: a byte-lane memory model and burst
// address arithmetic predict every R and B beat; one negedge process compares.
module tb_axi_mem_slave;

  localparam int ID_W      = 4;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MEM_DEPTH = 1024;
  localparam int BOUND     = 200;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [ID_W-1:0]   awid, wid, bid, arid, rid;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [7:0]        awlen, arlen;
  logic [2:0]        awsize, arsize;
  logic [1:0]        awburst, arburst, bresp, rresp;
  logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rlast, rvalid, rready;
  logic [DATA_W-1:0] wdata, rdata;
  logic [3:0]        wstrb;

  int tests  = 0;
  int failed = 0;

  logic [31:0] model_mem [MEM_DEPTH];
  logic [38:0] exp_r_q [$];   // {id, last, resp, data}
  logic [5:0]  exp_b_q [$];   // {id, resp}

  always #5 aclk = ~aclk;

  axi_mem_slave #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    tests++;
    failed++;
    $display("FAIL %s: no progress within %0d cycles", name, BOUND);
  endtask

  // ---------------- model ----------------
  function automatic logic wrap_ok(input logic [7:0] len);
    return (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst, input int k);
    logic [31:0] step, cont, lower;
    step = 32'd1 << size;
    if (burst == 2'd0) return start;
    if (burst == 2'd2 && wrap_ok(len)) begin
      cont  = (32'(len) + 32'd1) * step;
      lower = (start / cont) * cont;
      return lower + ((start - lower + 32'(k) * step) % cont);
    end
    return start + 32'(k) * step;
  endfunction

  function automatic logic shape_err(input logic [31:0] start, input logic [7:0] len,
                                     input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] step;
    step = 32'd1 << size;
    if (size > 3'd2 || burst == 2'd3) return 1'b1;
    if (burst == 2'd2 && (!wrap_ok(len) || (start % step) != 32'd0)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] worse(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic in_range(input logic [31:0] a);
    return (a / 32'd4) < 32'(MEM_DEPTH);
  endfunction

  // ---------------- driver tasks ----------------
  function automatic logic rdy(input int ch);
    case (ch)
      0:       return awready;
      1:       return wready;
      2:       return arready;
      default: return bvalid;
    endcase
  endfunction

  task automatic wait_hs(input int ch, input string name);
    int n = 0;
    while (!rdy(ch) && n < BOUND) begin
      @(posedge aclk); #1;
      n++;
    end
    if (!rdy(ch)) bound_fail(name);
    @(posedge aclk); #1;
  endtask

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [31:0] base,
                           input logic [3:0] strb, input int bad_last, input int b_hold);
    logic [1:0]  resp;
    logic [31:0] a, d;
    logic        lst;
    int          n;
    resp = 2'd0;
    for (int k = 0; k <= int'(len); k++) begin
      a    = beat_addr(addr, len, size, burst, k);
      lst  = (bad_last >= 0) ? (k == bad_last) : (k == int'(len));
      resp = worse(resp, !in_range(a) ? 2'd3 :
                         (shape_err(addr, len, size, burst) || lst != (k == int'(len))) ? 2'd2 : 2'd0);
    end
    exp_b_q.push_back({id, resp});
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    wait_hs(0, "aw_handshake");
    awvalid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      a = beat_addr(addr, len, size, burst, k);
      d = base + 32'(k);
      wid = id; wdata = d; wstrb = strb;
      wlast  = (bad_last >= 0) ? (k == bad_last) : (k == int'(len));
      wvalid = 1'b1;
      wait_hs(1, "w_handshake");
      if (in_range(a))
        for (int i = 0; i < 4; i++)
          if (strb[i]) model_mem[a[11:2]][8*i +: 8] = d[8*i +: 8];
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    if (b_hold > 0) begin
      bready = 1'b0;
      n = 0;
      while (!bvalid && n < BOUND) begin
        @(posedge aclk); #1;
        n++;
      end
      repeat (b_hold) begin
        @(posedge aclk); #1;
      end
      bready = 1'b1;
    end
    wait_hs(3, "b_handshake");
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int stall);
    logic [31:0] a;
    logic [1:0]  resp;
    int          n;
    for (int k = 0; k <= int'(len); k++) begin
      a    = beat_addr(addr, len, size, burst, k);
      resp = !in_range(a) ? 2'd3 : (shape_err(addr, len, size, burst) ? 2'd2 : 2'd0);
      exp_r_q.push_back({id, (k == int'(len)), resp, in_range(a) ? model_mem[a[11:2]] : 32'd0});
    end
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    wait_hs(2, "ar_handshake");
    arvalid = 1'b0;
    n = 0;
    if (stall > 0) begin
      while (exp_r_q.size() > int'(len) && n < BOUND) begin
        @(posedge aclk); #1;
        n++;
      end
      rready = 1'b0;
      repeat (stall) begin
        @(posedge aclk); #1;
      end
      rready = 1'b1;
    end
    while (exp_r_q.size() > 0 && n < BOUND) begin
      @(posedge aclk); #1;
      n++;
    end
    if (exp_r_q.size() > 0) begin
      bound_fail("r_beats");
      exp_r_q.delete();
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  logic        r_held, b_held, held_rlast;
  logic [31:0] held_rdata;
  logic [5:0]  held_b;
  logic [38:0] re;
  logic [5:0]  be;

  always @(negedge aclk) begin
    if (!aresetn) begin
      r_held = 1'b0;
      b_held = 1'b0;
    end else begin
      if (rvalid && rready) begin
        r_held = 1'b0;
        if (exp_r_q.size() == 0) begin
          tests++; failed++;
          $display("FAIL r_unexpected: got beat rdata=0x%0h, want no beat", rdata);
        end else begin
          re = exp_r_q.pop_front();
          check("r_data", 64'(rdata), 64'(re[31:0]));
          check("r_resp", 64'(rresp), 64'(re[33:32]));
          check("r_last", 64'(rlast), 64'(re[34]));
          check("r_id",   64'(rid),   64'(re[38:35]));
        end
      end else if (rvalid) begin
        if (r_held) begin
          check("r_hold_data", 64'(rdata), 64'(held_rdata));
          check("r_hold_last", 64'(rlast), 64'(held_rlast));
        end
        r_held = 1'b1; held_rdata = rdata; held_rlast = rlast;
      end else begin
        r_held = 1'b0;
      end

      if (bvalid && bready) begin
        b_held = 1'b0;
        if (exp_b_q.size() == 0) begin
          tests++; failed++;
          $display("FAIL b_unexpected: got bvalid bresp=%0d, want no response", bresp);
        end else begin
          be = exp_b_q.pop_front();
          check("b_resp", 64'(bresp), 64'(be[1:0]));
          check("b_id",   64'(bid),   64'(be[5:2]));
        end
      end else if (bvalid) begin
        if (b_held) check("b_hold", 64'({bid, bresp}), 64'(held_b));
        b_held = 1'b1; held_b = {bid, bresp};
      end else begin
        b_held = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    aresetn = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b1;
    for (int i = 0; i < MEM_DEPTH; i++) model_mem[i] = 32'd0;

    repeat (3) @(posedge aclk);
    #1;
    check("rst_awready", 64'(awready), 64'd0);
    check("rst_arready", 64'(arready), 64'd0);
    check("rst_outputs", 64'({wready, bvalid, rvalid, rlast, bresp, rresp}), 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    check("awready_before_edge", 64'(awready), 64'd0);
    @(posedge aclk); #1;
    check("awready_after_release", 64'(awready), 64'd1);
    check("arready_after_release", 64'(arready), 64'd1);

    // Prefill words 0..31 with a known pattern.
    axi_write(4'd1, 32'h0, 8'd31, 3'd2, 2'd1, 32'hC0DE0000, 4'hF, -1, 0);

    // INCR write/read round trip with a 5-cycle R stall mid-burst.
    axi_write(4'd5, 32'h10, 8'd3, 3'd2, 2'd1, 32'hA0, 4'hF, -1, 0);
    check("pin_incr_word", 64'(model_mem[4]), 64'h0A0);
    axi_read(4'd3, 32'h10, 8'd3, 3'd2, 2'd1, 5);

    // WRAP read from 0x38: 0x38, 0x3C, 0x30, 0x34.
    check("pin_wrap_beat2", 64'(beat_addr(32'h38, 8'd3, 3'd2, 2'd2, 2)), 64'h30);
    axi_read(4'd7, 32'h38, 8'd3, 3'd2, 2'd2, 0);

    // FIXED write of 1,2,3 to 0x40 leaves 3; B held off for 3 cycles.
    axi_write(4'd2, 32'h40, 8'd2, 3'd2, 2'd0, 32'd1, 4'hF, -1, 3);
    check("pin_fixed", 64'(model_mem[16]), 64'd3);
    axi_read(4'd2, 32'h40, 8'd0, 3'd2, 2'd1, 0);

    // Partial strobe over 0x11223344.
    axi_write(4'd4, 32'h44, 8'd0, 3'd2, 2'd1, 32'h11223344, 4'hF, -1, 0);
    axi_write(4'd4, 32'h44, 8'd0, 3'd2, 2'd1, 32'hDEADBEEF, 4'h3, -1, 0);
    check("pin_partial", 64'(model_mem[17]), 64'h1122BEEF);
    axi_read(4'd4, 32'h44, 8'd0, 3'd2, 2'd1, 0);

    // DECERR read past the end and shape errors.
    axi_read(4'd8, 32'(MEM_DEPTH * 4), 8'd0, 3'd2, 2'd1, 0);
    axi_read(4'd9, 32'h0, 8'd1, 3'd3, 2'd1, 0);
    axi_read(4'd10, 32'h4, 8'd1, 3'd2, 2'd3, 0);
    axi_read(4'd11, 32'h30, 8'd2, 3'd2, 2'd2, 0);

    // Early wlast: SLVERR, yet all four beats land.
    axi_write(4'd9, 32'h70, 8'd3, 3'd2, 2'd1, 32'hB0, 4'hF, 1, 0);
    axi_read(4'd9, 32'h70, 8'd3, 3'd2, 2'd1, 0);

    // Simultaneous AW and AR on one word: the read sees the old value.
    fork
      axi_write(4'd12, 32'h20, 8'd0, 3'd2, 2'd1, 32'h55AA55AA, 4'hF, -1, 0);
      axi_read(4'd13, 32'h20, 8'd0, 3'd2, 2'd1, 0);
    join
    axi_read(4'd13, 32'h20, 8'd0, 3'd2, 2'd1, 0);

    // Reset during W beat 2 of a 4-beat write to 0x60.
    awid = 4'd6; awaddr = 32'h60; awlen = 8'd3; awsize = 3'd2; awburst = 2'd1; awvalid = 1'b1;
    wait_hs(0, "aw_handshake");
    awvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wid = 4'd6; wdata = 32'h77000000 + 32'(k); wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
      wait_hs(1, "w_handshake");
      model_mem[24 + k] = 32'h77000000 + 32'(k);
    end
    wdata = 32'h77000002; wvalid = 1'b1;
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check("midrst_awready", 64'(awready), 64'd0);
    check("midrst_wready",  64'(wready),  64'd0);
    check("midrst_bvalid",  64'(bvalid),  64'd0);
    check("midrst_read_side", 64'({arready, rvalid, rlast, rresp, rdata}), 64'd0);
    wvalid = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    check("midrst_awready_pre_edge", 64'(awready), 64'd0);
    @(posedge aclk); #1;
    check("midrst_awready_released", 64'(awready), 64'd1);
    repeat (10) @(posedge aclk);
    #1;
    check("midrst_no_bvalid", 64'(bvalid), 64'd0);
    axi_read(4'd6, 32'h60, 8'd3, 3'd2, 2'd1, 0);

    repeat (3) @(posedge aclk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
